// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcodes, datapath/ALU bit indices, sequencer types.
package minisrc_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Datapath enable / driver bit indices (shared by DPin and DPout)
  localparam int unsigned DP_PC      = 0;
  localparam int unsigned DP_IR      = 1;
  localparam int unsigned DP_Y       = 2;
  localparam int unsigned DP_MAR     = 3;
  localparam int unsigned DP_MDR     = 4;
  localparam int unsigned DP_INPORT  = 5;
  localparam int unsigned DP_OUTPORT = 6;
  localparam int unsigned DP_Z       = 7;
  localparam int unsigned DP_ZHI     = 8;
  localparam int unsigned DP_ZLO     = 9;
  localparam int unsigned DP_HI      = 10;
  localparam int unsigned DP_LO      = 11;
  localparam int unsigned DP_READ    = 12;
  localparam int unsigned DP_C       = 13;

  // ALU operation bit indices
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_NEG = 2;
  localparam int unsigned ALU_MUL = 3;
  localparam int unsigned ALU_DIV = 4;
  localparam int unsigned ALU_AND = 5;
  localparam int unsigned ALU_OR  = 6;
  localparam int unsigned ALU_ROR = 7;
  localparam int unsigned ALU_ROL = 8;
  localparam int unsigned ALU_SLL = 9;
  localparam int unsigned ALU_SRA = 10;
  localparam int unsigned ALU_SRL = 11;
  localparam int unsigned ALU_NOT = 12;
  localparam int unsigned ALU_INC = 13;

  typedef enum logic [3:0] {
    StRst, StF0, StF1, StF2, StF3,
    StE0, StE1, StE2, StE3, StE4, StE5,
    StHalt
  } state_e;

  typedef enum logic [3:0] {
    ClsRtype, ClsItype, ClsUnary, ClsMuldiv, ClsLd, ClsLdi, ClsSt, ClsBr,
    ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } op_class_e;

  // One-hot ALU operation for opcodes that use the ALU in their compute step
  function automatic logic [15:0] alu_sel(input logic [4:0] op);
    logic [15:0] sel;
    sel = '0;
    case (op)
      OP_ADD, OP_ADDI: sel[ALU_ADD] = 1'b1;
      OP_SUB:          sel[ALU_SUB] = 1'b1;
      OP_AND, OP_ANDI: sel[ALU_AND] = 1'b1;
      OP_OR, OP_ORI:   sel[ALU_OR]  = 1'b1;
      OP_ROR:          sel[ALU_ROR] = 1'b1;
      OP_ROL:          sel[ALU_ROL] = 1'b1;
      OP_SHR:          sel[ALU_SRL] = 1'b1;
      OP_SHRA:         sel[ALU_SRA] = 1'b1;
      OP_SHL:          sel[ALU_SLL] = 1'b1;
      OP_DIV:          sel[ALU_DIV] = 1'b1;
      OP_MUL:          sel[ALU_MUL] = 1'b1;
      OP_NEG:          sel[ALU_NEG] = 1'b1;
      OP_NOT:          sel[ALU_NOT] = 1'b1;
      default:         sel = '0;
    endcase
    return sel;
  endfunction

  // Index of the final execute step for each class
  function automatic logic [2:0] last_step(input op_class_e cls);
    logic [2:0] n;
    case (cls)
      ClsRtype, ClsItype, ClsLdi: n = 3'd2;
      ClsUnary, ClsJal:           n = 3'd1;
      ClsMuldiv, ClsBr:           n = 3'd3;
      ClsSt:                      n = 3'd4;
      ClsLd:                      n = 3'd5;
      default:                    n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/control_unit_op_class_decode.sv
// Combinational opcode to instruction-class decode.
module op_class_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] IRop,
  output op_class_e  op_class
);

  // Map each opcode onto the execute sequence it follows
  always_comb begin
    op_class = ClsNop;
    case (IRop)
      OP_LD:   op_class = ClsLd;
      OP_LDI:  op_class = ClsLdi;
      OP_ST:   op_class = ClsSt;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               op_class = ClsRtype;
      OP_ADDI, OP_ANDI, OP_ORI:
               op_class = ClsItype;
      OP_DIV, OP_MUL:
               op_class = ClsMuldiv;
      OP_NEG, OP_NOT:
               op_class = ClsUnary;
      OP_BR:   op_class = ClsBr;
      OP_JR:   op_class = ClsJr;
      OP_JAL:  op_class = ClsJal;
      OP_IN:   op_class = ClsIn;
      OP_OUT:  op_class = ClsOut;
      OP_MFHI: op_class = ClsMfhi;
      OP_MFLO: op_class = ClsMflo;
      OP_HALT: op_class = ClsHalt;
      default: op_class = ClsNop; // nop and the reserved 111xx codes
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Mini SRC sequencer: 4-step fetch, class-specific execute, halt/stop handling.
module control_unit
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  IRop,
  input  logic        CON,
  input  logic        stop,
  output logic [15:0] DPin,
  output logic [15:0] DPout,
  output logic [15:0] ALUopp,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        RAM_wr,
  output logic        CONin,
  output logic        run
);

  state_e    state_q, state_d;
  logic      stop_q;
  op_class_e cls;
  logic [2:0] e_step;
  logic       halt_req;
  logic       e_last;

  op_class_decode u_decode (
    .IRop     (IRop),
    .op_class (cls)
  );

  // A stop pulse is remembered so the current instruction can finish first
  assign halt_req = stop | stop_q;
  assign e_last   = (e_step >= last_step(cls));

  // State register and sticky stop request
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StRst;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stop_q  <= stop_q | stop;
    end
  end

  // Execute step number for the current E-state
  always_comb begin
    e_step = 3'd0;
    case (state_q)
      StE1:    e_step = 3'd1;
      StE2:    e_step = 3'd2;
      StE3:    e_step = 3'd3;
      StE4:    e_step = 3'd4;
      StE5:    e_step = 3'd5;
      default: e_step = 3'd0;
    endcase
  end

  // Next-state: fetch, branch on class in F3, walk E-steps, divert to HALT on stop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:  state_d = halt_req ? StHalt : StF0;
      StF0:   state_d = StF1;
      StF1:   state_d = StF2;
      StF2:   state_d = StF3;
      StF3: begin
        if (cls == ClsHalt)     state_d = StHalt;
        else if (cls == ClsNop) state_d = halt_req ? StHalt : StF0;
        else                    state_d = StE0;
      end
      StE0, StE1, StE2, StE3, StE4, StE5: begin
        if (e_last) begin
          state_d = halt_req ? StHalt : StF0;
        end else begin
          case (state_q)
            StE0:    state_d = StE1;
            StE1:    state_d = StE2;
            StE2:    state_d = StE3;
            StE3:    state_d = StE4;
            default: state_d = StE5;
          endcase
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // Moore output decode from state and opcode class
  always_comb begin
    DPin   = '0;
    DPout  = '0;
    ALUopp = '0;
    Gra    = 1'b0;
    Grb    = 1'b0;
    Grc    = 1'b0;
    Rin    = 1'b0;
    Rout   = 1'b0;
    BAout  = 1'b0;
    RAM_wr = 1'b0;
    CONin  = 1'b0;
    run    = (state_q != StRst) && (state_q != StHalt);
    unique case (state_q)
      StF0: begin
        DPout[DP_PC] = 1'b1;
        DPin[DP_MAR] = 1'b1;
        DPin[DP_Z]   = 1'b1;
        ALUopp[ALU_INC] = 1'b1;
      end
      StF1: begin
        DPout[DP_ZLO] = 1'b1;
        DPin[DP_PC]   = 1'b1;
      end
      StF2: begin
        DPin[DP_READ] = 1'b1;
        DPin[DP_MDR]  = 1'b1;
      end
      StF3: begin
        DPout[DP_MDR] = 1'b1;
        DPin[DP_IR]   = 1'b1;
      end
      StE0, StE1, StE2, StE3, StE4, StE5: begin
        unique case (cls)
          ClsRtype, ClsItype: begin
            case (e_step)
              3'd0: begin Grb = 1'b1; Rout = 1'b1; DPin[DP_Y] = 1'b1; end
              3'd1: begin
                if (cls == ClsRtype) begin
                  Grc  = 1'b1;
                  Rout = 1'b1;
                end else begin
                  DPout[DP_C] = 1'b1;
                end
                ALUopp = alu_sel(IRop);
                DPin[DP_Z] = 1'b1;
              end
              3'd2: begin DPout[DP_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          ClsUnary: begin
            case (e_step)
              3'd0: begin
                Grb = 1'b1; Rout = 1'b1; ALUopp = alu_sel(IRop); DPin[DP_Z] = 1'b1;
              end
              3'd1: begin DPout[DP_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          ClsMuldiv: begin
            case (e_step)
              3'd0: begin Gra = 1'b1; Rout = 1'b1; DPin[DP_Y] = 1'b1; end
              3'd1: begin
                Grb = 1'b1; Rout = 1'b1; ALUopp = alu_sel(IRop); DPin[DP_Z] = 1'b1;
              end
              3'd2: begin DPout[DP_ZLO] = 1'b1; DPin[DP_LO] = 1'b1; end
              3'd3: begin DPout[DP_ZHI] = 1'b1; DPin[DP_HI] = 1'b1; end
              default: ;
            endcase
          end
          ClsLd, ClsLdi, ClsSt: begin
            // Effective address (rb + C, or C when rb is r0) is shared by all three
            case (e_step)
              3'd0: begin Grb = 1'b1; BAout = 1'b1; DPin[DP_Y] = 1'b1; end
              3'd1: begin DPout[DP_C] = 1'b1; ALUopp[ALU_ADD] = 1'b1; DPin[DP_Z] = 1'b1; end
              3'd2: begin
                DPout[DP_ZLO] = 1'b1;
                if (cls == ClsLdi) begin
                  Gra = 1'b1;
                  Rin = 1'b1;
                end else begin
                  DPin[DP_MAR] = 1'b1;
                end
              end
              3'd3: begin
                if (cls == ClsSt) begin
                  Gra = 1'b1; Rout = 1'b1; DPin[DP_MDR] = 1'b1;
                end
              end
              3'd4: begin
                if (cls == ClsSt) begin
                  RAM_wr = 1'b1;
                end else begin
                  DPin[DP_READ] = 1'b1; DPin[DP_MDR] = 1'b1;
                end
              end
              3'd5: begin DPout[DP_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          ClsBr: begin
            case (e_step)
              3'd0: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              3'd1: begin DPout[DP_PC] = 1'b1; DPin[DP_Y] = 1'b1; end
              3'd2: begin DPout[DP_C] = 1'b1; ALUopp[ALU_ADD] = 1'b1; DPin[DP_Z] = 1'b1; end
              3'd3: begin DPout[DP_ZLO] = 1'b1; DPin[DP_PC] = CON; end
              default: ;
            endcase
          end
          ClsJr: begin Gra = 1'b1; Rout = 1'b1; DPin[DP_PC] = 1'b1; end
          ClsJal: begin
            if (e_step == 3'd0) begin
              DPout[DP_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1;
            end else begin
              Gra = 1'b1; Rout = 1'b1; DPin[DP_PC] = 1'b1;
            end
          end
          ClsIn:   begin DPout[DP_INPORT] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsOut:  begin Gra = 1'b1; Rout = 1'b1; DPin[DP_OUTPORT] = 1'b1; end
          ClsMfhi: begin DPout[DP_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          ClsMflo: begin DPout[DP_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-instruction expected cycle vectors from an opcode table.
module tb_control_unit;

  typedef struct packed {
    logic [15:0] dpin;
    logic [15:0] dpout;
    logic [15:0] alu;
    logic [7:0]  ctl;  // {Gra,Grb,Grc,Rin,Rout,BAout,RAM_wr,CONin}
    logic        run;
  } vec_t;

  localparam logic [15:0] B_PC = 16'h0001, B_IR = 16'h0002, B_Y = 16'h0004, B_MAR = 16'h0008;
  localparam logic [15:0] B_MDR = 16'h0010, B_INP = 16'h0020, B_OUTP = 16'h0040;
  localparam logic [15:0] B_Z = 16'h0080, B_ZHI = 16'h0100, B_ZLO = 16'h0200, B_HI = 16'h0400;
  localparam logic [15:0] B_LO = 16'h0800, B_READ = 16'h1000, B_C = 16'h2000;
  localparam logic [15:0] A_ADD = 16'h0001, A_SUB = 16'h0002, A_NEG = 16'h0004;
  localparam logic [15:0] A_MUL = 16'h0008, A_DIV = 16'h0010, A_AND = 16'h0020;
  localparam logic [15:0] A_OR = 16'h0040, A_ROR = 16'h0080, A_ROL = 16'h0100;
  localparam logic [15:0] A_SLL = 16'h0200, A_SRA = 16'h0400, A_SRL = 16'h0800;
  localparam logic [15:0] A_NOT = 16'h1000, A_INC = 16'h2000;
  localparam logic [7:0] GRA = 8'h80, GRB = 8'h40, GRC = 8'h20, RIN = 8'h10;
  localparam logic [7:0] ROUT = 8'h08, BAOUT = 8'h04, RAMWR = 8'h02, CONIN = 8'h01;

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  IRop;
  logic        CON;
  logic        stop;
  logic [15:0] DPin, DPout, ALUopp;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, RAM_wr, CONin, run;

  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_len;
  int   push_limit = 1000;

  control_unit dut (
    .clk    (clk),
    .clr    (clr),
    .IRop   (IRop),
    .CON    (CON),
    .stop   (stop),
    .DPin   (DPin),
    .DPout  (DPout),
    .ALUopp (ALUopp),
    .Gra    (Gra),
    .Grb    (Grb),
    .Grc    (Grc),
    .Rin    (Rin),
    .Rout   (Rout),
    .BAout  (BAout),
    .RAM_wr (RAM_wr),
    .CONin  (CONin),
    .run    (run)
  );

  always #5 clk = ~clk;

  function automatic vec_t cur();
    vec_t v;
    v.dpin  = DPin;
    v.dpout = DPout;
    v.alu   = ALUopp;
    v.ctl   = {Gra, Grb, Grc, Rin, Rout, BAout, RAM_wr, CONin};
    v.run   = run;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string name, input vec_t act, input vec_t want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic check_num(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic add_step(input logic [15:0] din, input logic [15:0] dout,
                          input logic [15:0] alu, input logic [7:0] ctl);
    vec_t v;
    v.dpin = din; v.dpout = dout; v.alu = alu; v.ctl = ctl; v.run = 1'b1;
    if (model_len < push_limit) exp_q.push_back(v);
    model_len++;
  endtask

  // ALU operation each computing opcode requests
  function automatic logic [15:0] op_alu(input int op);
    case (op)
      3, 12:   return A_ADD;
      4:       return A_SUB;
      5, 13:   return A_AND;
      6, 14:   return A_OR;
      7:       return A_ROR;
      8:       return A_ROL;
      9:       return A_SRL;
      10:      return A_SRA;
      11:      return A_SLL;
      15:      return A_DIV;
      16:      return A_MUL;
      17:      return A_NEG;
      18:      return A_NOT;
      default: return 16'h0000;
    endcase
  endfunction

  // Reference: the full cycle-by-cycle control word sequence of one instruction
  task automatic model_instr(input int op, input logic con);
    logic [15:0] a;
    a = op_alu(op);
    model_len = 0;
    add_step(B_MAR | B_Z, B_PC, A_INC, 8'h00);
    add_step(B_PC, B_ZLO, 16'h0, 8'h00);
    add_step(B_MDR | B_READ, 16'h0, 16'h0, 8'h00);
    add_step(B_IR, B_MDR, 16'h0, 8'h00);
    if (op >= 3 && op <= 11) begin
      add_step(B_Y, 16'h0, 16'h0, GRB | ROUT);
      add_step(B_Z, 16'h0, a, GRC | ROUT);
      add_step(16'h0, B_ZLO, 16'h0, GRA | RIN);
    end else if (op >= 12 && op <= 14) begin
      add_step(B_Y, 16'h0, 16'h0, GRB | ROUT);
      add_step(B_Z, B_C, a, 8'h00);
      add_step(16'h0, B_ZLO, 16'h0, GRA | RIN);
    end else if (op == 15 || op == 16) begin
      add_step(B_Y, 16'h0, 16'h0, GRA | ROUT);
      add_step(B_Z, 16'h0, a, GRB | ROUT);
      add_step(B_LO, B_ZLO, 16'h0, 8'h00);
      add_step(B_HI, B_ZHI, 16'h0, 8'h00);
    end else if (op == 17 || op == 18) begin
      add_step(B_Z, 16'h0, a, GRB | ROUT);
      add_step(16'h0, B_ZLO, 16'h0, GRA | RIN);
    end else if (op <= 2) begin
      add_step(B_Y, 16'h0, 16'h0, GRB | BAOUT);
      add_step(B_Z, B_C, A_ADD, 8'h00);
      if (op == 1) begin
        add_step(16'h0, B_ZLO, 16'h0, GRA | RIN);
      end else if (op == 0) begin
        add_step(B_MAR, B_ZLO, 16'h0, 8'h00);
        add_step(16'h0, 16'h0, 16'h0, 8'h00);
        add_step(B_MDR | B_READ, 16'h0, 16'h0, 8'h00);
        add_step(16'h0, B_MDR, 16'h0, GRA | RIN);
      end else begin
        add_step(B_MAR, B_ZLO, 16'h0, 8'h00);
        add_step(B_MDR, 16'h0, 16'h0, GRA | ROUT);
        add_step(16'h0, 16'h0, 16'h0, RAMWR);
      end
    end else if (op == 19) begin
      add_step(16'h0, 16'h0, 16'h0, GRA | ROUT | CONIN);
      add_step(B_Y, B_PC, 16'h0, 8'h00);
      add_step(B_Z, B_C, A_ADD, 8'h00);
      add_step(con ? B_PC : 16'h0, B_ZLO, 16'h0, 8'h00);
    end else if (op == 20) begin
      add_step(B_PC, 16'h0, 16'h0, GRA | ROUT);
    end else if (op == 21) begin
      add_step(16'h0, B_PC, 16'h0, GRB | RIN);
      add_step(B_PC, 16'h0, 16'h0, GRA | ROUT);
    end else if (op == 22) begin
      add_step(16'h0, B_INP, 16'h0, GRA | RIN);
    end else if (op == 23) begin
      add_step(B_OUTP, 16'h0, 16'h0, GRA | ROUT);
    end else if (op == 24) begin
      add_step(16'h0, B_HI, 16'h0, GRA | RIN);
    end else if (op == 25) begin
      add_step(16'h0, B_LO, 16'h0, GRA | RIN);
    end
    // nop (26, 28-31) and halt (27) are fetch only
  endtask

  // Entered just after the edge into F0; leaves just after the next F0 edge
  task automatic run_instr(input int op, input logic con);
    IRop = 5'(op);
    CON  = con;
    model_instr(op, con);
    repeat (model_len) step();
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      check_vec(name, cur(), '0);
      step();
    end
  endtask

  task automatic restart();
    clr = 1'b1;
    step();
    check_vec("clr_outputs", cur(), '0);
    clr = 1'b0;
    step();
  endtask

  // Monitor: every sequencing cycle must match the next expected control word
  always @(negedge clk) begin
    vec_t want;
    if (!clr && run) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output got=%h want=<none>", cur());
      end else begin
        want = exp_q.pop_front();
        if (cur() !== want) begin
          n_err++;
          $display("FAIL scoreboard got=%h want=%h", cur(), want);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int op;
    clr = 1'b1; IRop = 5'd0; CON = 1'b0; stop = 1'b0;
    repeat (3) step();
    check_vec("reset_outputs", cur(), '0);
    clr = 1'b0;
    step();

    // Every opcode once, branch both ways
    for (int o = 0; o < 32; o++) begin
      if (o != 27) run_instr(o, 1'b0);
    end
    run_instr(19, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 31));
      if (op == 27) op = 26;
      run_instr(op, 1'($urandom_range(0, 1)));
    end
    check_num("drain_random", exp_q.size(), 0);

    // stop pulsed in add E1: add completes, then halt
    IRop = 5'd3;
    CON  = 1'b0;
    model_instr(3, 1'b0);
    repeat (5) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    check_num("stop_run_low", int'(run), 0);
    check_idle("stop_halt_idle", 20);
    check_num("drain_stop", exp_q.size(), 0);
    restart();

    // halt instruction
    run_instr(27, 1'b0);
    check_num("halt_run_low", int'(run), 0);
    check_idle("halt_idle", 20);
    check_num("drain_halt", exp_q.size(), 0);
    restart();

    // clr in st E3 aborts before the write step
    IRop = 5'd2;
    push_limit = 7;
    model_instr(2, 1'b0);
    push_limit = 1000;
    repeat (7) step();
    clr = 1'b1;
    #1;
    check_num("abort_ram_wr", int'(RAM_wr), 0);
    check_vec("abort_outputs", cur(), '0);
    check_num("drain_abort", exp_q.size(), 0);
    step();
    check_num("abort_held_ram_wr", int'(RAM_wr), 0);
    clr = 1'b0;
    step();
    run_instr(3, 1'b0);
    run_instr(26, 1'b0);
    check_num("drain_final", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
